// File: rtl/status_register_unit_if.sv
// Bundles the EXE-stage flag-write inputs, exception strobes and status outputs
// of the status register unit.
interface status_register_unit_if #(
    parameter int LEN_STATUS = 4
);
    logic                  exe_valid;
    logic                  exe_s;
    logic [LEN_STATUS-1:0] exe_flags;
    logic [LEN_STATUS-1:0] exe_mask;
    logic                  freeze;
    logic                  exc_enter;
    logic                  exc_return;
    logic [LEN_STATUS-1:0] status_register;
    logic [LEN_STATUS-1:0] status_fwd;
    logic                  in_exception;
    logic                  exc_error;
    logic [7:0]            update_count;

    modport master (
        output exe_valid, exe_s, exe_flags, exe_mask, freeze, exc_enter, exc_return,
        input  status_register, status_fwd, in_exception, exc_error, update_count
    );

    modport slave (
        input  exe_valid, exe_s, exe_flags, exe_mask, freeze, exc_enter, exc_return,
        output status_register, status_fwd, in_exception, exc_error, update_count
    );
endinterface

// File: rtl/status_register_unit.sv
// Architectural {N,Z,C,V} flag register with masked commit, zero-latency bypass
// and a one-deep exception shadow for save/restore on exception entry/return.
module status_register_unit #(
    parameter int LEN_STATUS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    status_register_unit_if.slave   bus
);

    typedef enum logic [0:0] {
        NORM = 1'b0,
        EXC  = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [LEN_STATUS-1:0] status_r;
    logic [LEN_STATUS-1:0] status_nxt_s;
    logic [LEN_STATUS-1:0] shadow_r;
    logic [LEN_STATUS-1:0] shadow_nxt_s;
    logic                  exc_error_r;
    logic                  exc_error_nxt_s;
    logic [7:0]            count_r;
    logic                  commit_s;
    logic [LEN_STATUS-1:0] merged_s;
    logic [LEN_STATUS-1:0] fwd_s;

    function automatic logic [LEN_STATUS-1:0] merge_flags(
        input logic [LEN_STATUS-1:0] mask,
        input logic [LEN_STATUS-1:0] flags,
        input logic [LEN_STATUS-1:0] cur
    );
        return (mask & flags) | (~mask & cur);
    endfunction

    assign commit_s = bus.exe_valid & bus.exe_s & ~bus.freeze;
    assign merged_s = merge_flags(bus.exe_mask, bus.exe_flags, status_r);
    assign fwd_s    = commit_s ? merged_s : status_r;

    // Next-state decode: exception protocol and flag/shadow update selection.
    always_comb begin
        state_nxt_s     = state_r;
        status_nxt_s    = fwd_s;
        shadow_nxt_s    = shadow_r;
        exc_error_nxt_s = exc_error_r;
        case (state_r)
            NORM: begin
                if (bus.exc_enter && !bus.exc_return) begin
                    shadow_nxt_s = fwd_s;
                    state_nxt_s  = EXC;
                end else if (bus.exc_return) begin
                    // Return outside an exception, or enter+return together.
                    exc_error_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = NORM;
                end
            end
            EXC: begin
                if (bus.exc_return && !bus.exc_enter) begin
                    // Restore wins over any commit in the same cycle.
                    status_nxt_s = shadow_r;
                    state_nxt_s  = NORM;
                end else if (bus.exc_enter) begin
                    exc_error_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = EXC;
                end
            end
            default: begin
                state_nxt_s = NORM;
            end
        endcase
    end

    // State, flag, shadow and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= NORM;
            status_r    <= '0;
            shadow_r    <= '0;
            exc_error_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            status_r    <= status_nxt_s;
            shadow_r    <= shadow_nxt_s;
            exc_error_r <= exc_error_nxt_s;
        end
    end

    // Saturating count of committed flag writes; shadow restores do not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (commit_s && (count_r != 8'd255)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign bus.status_register = status_r;
    assign bus.status_fwd      = fwd_s;
    assign bus.in_exception    = (state_r == EXC);
    assign bus.exc_error       = exc_error_r;
    assign bus.update_count    = count_r;

endmodule

// File: tb/tb_status_register_unit.sv
// Directed-vector bench for status_register_unit: stimulus pushes expected
// observations into a scoreboard queue; a negedge monitor pops and compares.
module tb_status_register_unit;

    localparam int K_STATUS = 0;
    localparam int K_FWD    = 1;
    localparam int K_INEXC  = 2;
    localparam int K_ERR    = 3;
    localparam int K_COUNT  = 4;

    typedef struct {
        int         due;
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [7:0] mon_act;

    status_register_unit_if #(.LEN_STATUS(4)) ifc ();

    status_register_unit #(.LEN_STATUS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pick(input int kind);
        case (kind)
            K_STATUS: return {4'b0000, ifc.status_register};
            K_FWD:    return {4'b0000, ifc.status_fwd};
            K_INEXC:  return {7'b0000000, ifc.in_exception};
            K_ERR:    return {7'b0000000, ifc.exc_error};
            K_COUNT:  return ifc.update_count;
            default:  return 8'hxx;
        endcase
    endfunction

    // Monitor: compare every expectation that has come due this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e   = sb_q.pop_front();
            mon_act = pick(mon_e.kind);
            checks++;
            if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %0h expected %0h", mon_e.name, cyc, mon_act, mon_e.val);
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic [3:0] f, input logic [3:0] m,
                         input logic fr, input logic en, input logic rt);
        ifc.exe_valid  = v;
        ifc.exe_s      = s;
        ifc.exe_flags  = f;
        ifc.exe_mask   = m;
        ifc.freeze     = fr;
        ifc.exc_enter  = en;
        ifc.exc_return = rt;
    endtask

    task automatic expect_at(input int off, input int kind, input logic [7:0] val, input string nm);
        exp_t e;
        e.due  = cyc + off;
        e.kind = kind;
        e.val  = val;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        expect_at(0, K_FWD,    8'h0, "reset_fwd");
        expect_at(0, K_STATUS, 8'h0, "reset_status");
        expect_at(0, K_INEXC,  8'h0, "reset_inexc");
        expect_at(0, K_ERR,    8'h0, "reset_err");
        expect_at(0, K_COUNT,  8'd0, "reset_count");
        tick();

        // Full commit 1010
        drive(1'b1, 1'b1, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0);
        expect_at(0, K_FWD,    8'hA, "commit_fwd");
        expect_at(1, K_STATUS, 8'hA, "commit_status");
        expect_at(1, K_COUNT,  8'd1, "commit_count");
        tick();

        // Partial mask 1100 with flags 0101 -> 0110
        drive(1'b1, 1'b1, 4'b0101, 4'b1100, 1'b0, 1'b0, 1'b0);
        expect_at(0, K_FWD,    8'h6, "mask_fwd");
        expect_at(1, K_STATUS, 8'h6, "mask_status");
        expect_at(1, K_COUNT,  8'd2, "mask_count");
        tick();

        // Frozen commit is suppressed
        drive(1'b1, 1'b1, 4'b0101, 4'b1100, 1'b1, 1'b0, 1'b0);
        expect_at(0, K_FWD,    8'h6, "freeze_fwd");
        expect_at(1, K_STATUS, 8'h6, "freeze_status");
        expect_at(1, K_COUNT,  8'd2, "freeze_count");
        tick();

        // Not valid / no S bit: no commit
        drive(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
        expect_at(0, K_FWD,    8'h6, "novalid_fwd");
        expect_at(1, K_COUNT,  8'd2, "novalid_count");
        tick();
        drive(1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
        expect_at(1, K_STATUS, 8'h6, "nos_status");
        expect_at(1, K_COUNT,  8'd2, "nos_count");
        tick();

        // Zero mask still counts as a commit
        drive(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        expect_at(0, K_FWD,    8'h6, "zmask_fwd");
        expect_at(1, K_STATUS, 8'h6, "zmask_status");
        expect_at(1, K_COUNT,  8'd3, "zmask_count");
        tick();

        // Exception entry with same-cycle commit 1111 -> shadow 1111
        drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
        expect_at(0, K_FWD,    8'hF, "enter_fwd");
        expect_at(1, K_STATUS, 8'hF, "enter_status");
        expect_at(1, K_INEXC,  8'h1, "enter_inexc");
        expect_at(1, K_COUNT,  8'd4, "enter_count");
        expect_at(1, K_ERR,    8'h0, "enter_err");
        tick();

        // Commit 0000 inside the exception
        drive(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        expect_at(0, K_FWD,    8'h0, "exc_commit_fwd");
        expect_at(1, K_STATUS, 8'h0, "exc_commit_status");
        expect_at(1, K_INEXC,  8'h1, "exc_commit_inexc");
        tick();

        // Return with commit 1010: shadow restore overrides
        drive(1'b1, 1'b1, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b1);
        expect_at(0, K_FWD,    8'hA, "return_fwd");
        expect_at(1, K_STATUS, 8'hF, "return_status");
        expect_at(1, K_INEXC,  8'h0, "return_inexc");
        tick();

        // Return while in NORM -> sticky error, stays NORM
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        expect_at(1, K_ERR,    8'h1, "badret_err");
        expect_at(1, K_INEXC,  8'h0, "badret_inexc");
        expect_at(1, K_STATUS, 8'hF, "badret_status");
        tick();

        // Enter (shadow 1111), then commit 0011
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        expect_at(1, K_INEXC,  8'h1, "enter2_inexc");
        tick();
        drive(1'b1, 1'b1, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0);
        expect_at(1, K_STATUS, 8'h3, "exc2_commit_status");
        tick();

        // Nested enter with frozen commit: error stays, shadow unchanged
        drive(1'b1, 1'b1, 4'b1100, 4'b1111, 1'b1, 1'b1, 1'b0);
        expect_at(1, K_ERR,    8'h1, "nest_err");
        expect_at(1, K_INEXC,  8'h1, "nest_inexc");
        expect_at(1, K_STATUS, 8'h3, "nest_status");
        tick();

        // Enter and return together in EXC: no state change, no restore
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        expect_at(1, K_INEXC,  8'h1, "both_exc_inexc");
        expect_at(1, K_STATUS, 8'h3, "both_exc_status");
        tick();

        // Frozen return still restores the original shadow
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        expect_at(1, K_STATUS, 8'hF, "ret2_status");
        expect_at(1, K_INEXC,  8'h0, "ret2_inexc");
        tick();

        // Enter and return together in NORM: stays NORM
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        expect_at(1, K_INEXC,  8'h0, "both_norm_inexc");
        tick();

        // Frozen enter still enters
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
        expect_at(1, K_INEXC,  8'h1, "frz_enter_inexc");
        tick();

        // 300 consecutive commits saturate the counter
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        expect_at(0, K_COUNT,  8'd255, "sat_count");
        expect_at(1, K_COUNT,  8'd255, "sat_hold_count");
        tick();
        drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        expect_at(1, K_COUNT,  8'd255, "sat_commit_count");
        tick();

        // Reset in EXC with active commit and enter
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
        expect_at(1, K_STATUS, 8'h0, "rst_status");
        expect_at(1, K_INEXC,  8'h0, "rst_inexc");
        expect_at(1, K_ERR,    8'h0, "rst_err");
        expect_at(1, K_COUNT,  8'd0, "rst_count");
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        expect_at(0, K_FWD,    8'h0, "rst_fwd");
        tick();

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_register_unit.md
STATUS_REGISTER_UNIT -- requirements
Module: status_register_unit

Interface
REQ-001 SHALL have parameter LEN_STATUS, default 4, status width; bit order {N,Z,C,V}, MSB = N.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port exe_valid  input  1  EXE-stage instruction valid.
REQ-005 SHALL have port exe_s  input  1  EXE instruction has S bit set (writes flags).
REQ-006 SHALL have port exe_flags  input  LEN_STATUS  ALU-produced {N,Z,C,V}.
REQ-007 SHALL have port exe_mask  input  LEN_STATUS  per-flag write enable, same bit order.
REQ-008 SHALL have port freeze  input  1  pipeline stall; suppresses flag commit.
REQ-009 SHALL have port exc_enter  input  1  exception entry strobe.
REQ-010 SHALL have port exc_return  input  1  exception return strobe.
REQ-011 SHALL have port status_register  output  LEN_STATUS  registered architectural flags.
REQ-012 SHALL have port status_fwd  output  LEN_STATUS  combinational forwarded flags for condition evaluation.
REQ-013 SHALL have port in_exception  output  1  high in state EXC.
REQ-014 SHALL have port exc_error  output  1  sticky protocol-error flag.
REQ-015 SHALL have port update_count  output  8  saturating count of committed flag updates.

Function
REQ-016 SHALL define commit = exe_valid & exe_s & ~freeze.
REQ-017 SHALL on commit, per bit i: next[i] = exe_mask[i] ? exe_flags[i] : status_register[i]; visible on status_register one cycle later.
REQ-018 SHALL drive status_fwd = merged value of REQ-017 when commit, else status_register (zero-latency bypass).
REQ-019 SHALL leave status_register unchanged when commit is low; exe_mask = 0 with commit SHALL still count as a commit.
REQ-020 SHALL implement FSM states NORM and EXC; state held in registers; in_exception = (state == EXC).
REQ-021 SHALL, in NORM with exc_enter=1, exc_return=0: shadow <= status_fwd (includes same-cycle commit); state -> EXC; status_register updated per REQ-017.
REQ-022 SHALL, in EXC with exc_return=1, exc_enter=0: status_register <= shadow, overriding any same-cycle commit; state -> NORM.
REQ-023 SHALL, on exc_enter in EXC (nesting), exc_return in NORM, or exc_enter & exc_return together: set exc_error, keep state and shadow unchanged; commit still applies per REQ-017.
REQ-024 SHALL hold exc_error high until rst.
REQ-025 SHALL increment update_count by 1 on each commit, saturating at 255; restoring from shadow SHALL NOT count.
REQ-026 SHALL ignore freeze for exc_enter/exc_return handling.

Reset
REQ-027 SHALL on rst=1 at clock edge: status_register = 0000, shadow = 0000, state = NORM, exc_error = 0, update_count = 0.
REQ-028 SHALL give rst priority over every other input, including mid-exception and same-cycle commit.
REQ-029 SHALL drive status_fwd = 0000 in the cycle after reset when commit is low.

Verification
REQ-030 Commit exe_flags=1010, mask=1111 -> status_fwd=1010 same cycle; status_register=1010 next cycle; update_count=1.
REQ-031 status=1010; commit flags=0101, mask=1100 (logical op) -> status_register=0110; freeze=1 on identical commit -> no change, count unchanged.
REQ-032 status=0110; exc_enter with commit flags=1111 mask=1111 -> shadow=1111, in_exception=1; later commit 0000; exc_return with commit 1010 -> status_register=1111, in_exception=0.
REQ-033 exc_return in NORM -> exc_error=1, state NORM; second exc_enter while in EXC -> exc_error stays 1, shadow unchanged; exc_enter & exc_return same cycle -> no state change.
REQ-034 300 consecutive commits -> update_count=255 and holds.
REQ-035 rst asserted in EXC with commit active -> next cycle status_register=0000, in_exception=0, exc_error=0, update_count=0.
